status_cond_unit: RTL and testbench

//  Flag-consumer end of the execute-stage status interface. Latches the 4-bit
//  {N,Z,C,V} status word from the ALU when the EXE-stage instruction has S=1.

---
 rtl/status_cond_unit.sv | 94 +++++++++
 tb/tb_status_cond_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/status_cond_unit.sv
// status_cond_unit
//   Flag-consumer end of the execute-stage status interface. It holds the
//   committed {N,Z,C,V} word and evaluates the ID-stage ARM condition field
//   against it. It also returns the committed carry to the ALU.
//
// Parameters
//   BYPASS_EN   1: the ID condition sees same-cycle EXE flags.
//               0: flag_hz is raised instead.
//
// Ports
//   clk         in   system clock; all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   sr_in[3:0]  in   {N,Z,C,V} from the execute stage
//   exe_valid   in   EXE stage holds a real instruction
//   s_exe       in   EXE instruction updates the flags
//   freeze      in   pipeline stall; blocks flag commit and the bypass
//   cond_id[3:0] in  condition field of the ID-stage instruction
//   cond_valid  in   ID stage holds a real instruction
//   cond_pass   out  ID instruction may execute
//   flag_hz     out  ID must stall one cycle for flags (BYPASS_EN=0 only)
//   c_out       out  committed carry for ADC/SBC
//   sr_q[3:0]   out  committed {N,Z,C,V}
module status_cond_unit #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sr_in,
  input  logic       exe_valid,
  input  logic       s_exe,
  input  logic       freeze,
  input  logic [3:0] cond_id,
  input  logic       cond_valid,
  output logic       cond_pass,
  output logic       flag_hz,
  output logic       c_out,
  output logic [3:0] sr_q
);

  logic [3:0] r_sr;
  logic       w_upd;
  logic [3:0] w_eff;
  logic       w_n, w_z, w_c, w_v;
  logic       w_tbl;
  logic       w_uncond;

  assign w_upd = exe_valid & s_exe & ~freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= 4'b0000;
    end else if (w_upd) begin
      r_sr <= sr_in;
    end
  end

  // When the bypass is disabled, the condition always sees the committed
  // word. The hazard output tells the consumer to discard that result.
  assign w_eff = (BYPASS_EN && w_upd) ? sr_in : r_sr;
  assign w_n   = w_eff[3];
  assign w_z   = w_eff[2];
  assign w_c   = w_eff[1];
  assign w_v   = w_eff[0];

  always_comb begin
    w_tbl = 1'b1;
    case (cond_id)
      4'h0: w_tbl = w_z;
      4'h1: w_tbl = ~w_z;
      4'h2: w_tbl = w_c;
      4'h3: w_tbl = ~w_c;
      4'h4: w_tbl = w_n;
      4'h5: w_tbl = ~w_n;
      4'h6: w_tbl = w_v;
      4'h7: w_tbl = ~w_v;
      4'h8: w_tbl = w_c & ~w_z;
      4'h9: w_tbl = ~w_c | w_z;
      4'hA: w_tbl = (w_n == w_v);
      4'hB: w_tbl = (w_n != w_v);
      4'hC: w_tbl = ~w_z & (w_n == w_v);
      4'hD: w_tbl = w_z | (w_n != w_v);
      default: w_tbl = 1'b1;
    endcase
  end

  // AL and the reserved code 0xF never depend on the flags, so they never stall.
  assign w_uncond  = (cond_id == 4'hE) || (cond_id == 4'hF);

  assign cond_pass = ~rst & cond_valid & w_tbl;
  assign flag_hz   = ~rst & ~BYPASS_EN & cond_valid & w_upd & ~w_uncond;
  assign c_out     = r_sr[1];
  assign sr_q      = r_sr;

endmodule

// File: tb/tb_status_cond_unit.sv
// tb_status_cond_unit
//   Randomized and directed bench for status_cond_unit. Two instances share
//   their stimulus: one with the bypass enabled and one with it disabled.
//   A flag-level reference model predicts every output on every cycle.
module tb_status_cond_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sr_in;
  logic       exe_valid, s_exe, freeze;
  logic [3:0] cond_id;
  logic       cond_valid;

  logic       pass_a, hz_a, cout_a;
  logic [3:0] srq_a;
  logic       pass_b, hz_b, cout_b;
  logic [3:0] srq_b;

  int n_pass  = 0;
  int n_total = 0;

  // reference state: individual flags
  bit ref_n, ref_z, ref_c, ref_v;
  bit ref_known = 1'b0;

  always #5 clk = ~clk;

  status_cond_unit #(.BYPASS_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .sr_in(sr_in), .exe_valid(exe_valid),
    .s_exe(s_exe), .freeze(freeze), .cond_id(cond_id),
    .cond_valid(cond_valid), .cond_pass(pass_a), .flag_hz(hz_a),
    .c_out(cout_a), .sr_q(srq_a)
  );

  status_cond_unit #(.BYPASS_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .sr_in(sr_in), .exe_valid(exe_valid),
    .s_exe(s_exe), .freeze(freeze), .cond_id(cond_id),
    .cond_valid(cond_valid), .cond_pass(pass_b), .flag_hz(hz_b),
    .c_out(cout_b), .sr_q(srq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Each even/odd code pair is a base predicate and its complement.
  function automatic bit cond_ok(input int c, input bit n, input bit z, input bit cf, input bit v);
    bit base;
    if (c >= 14) return 1'b1;
    case (c / 2)
      0: base = z;
      1: base = cf;
      2: base = n;
      3: base = v;
      4: base = cf && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  // Checks the current cycle's outputs against the model, then advances one edge.
  task automatic cycle();
    bit upd, en, eb, ec, ed;
    bit exp_pa, exp_pb, exp_hb;
    #1;
    upd = exe_valid && s_exe && !freeze;
    if (upd) begin
      en = sr_in[3]; eb = sr_in[2]; ec = sr_in[1]; ed = sr_in[0];
    end else begin
      en = ref_n; eb = ref_z; ec = ref_c; ed = ref_v;
    end
    exp_pa = !rst && cond_valid && cond_ok(int'(cond_id), en, eb, ec, ed);
    exp_pb = !rst && cond_valid && cond_ok(int'(cond_id), ref_n, ref_z, ref_c, ref_v);
    exp_hb = !rst && cond_valid && upd && (cond_id < 4'hE);
    if (rst || ref_known) begin
      chk("pass_byp", pass_a, exp_pa);
      chk("hz_byp",   hz_a,   1'b0);
      chk("hz_nobyp", hz_b,   exp_hb);
    end
    if (ref_known) begin
      chk("pass_nobyp", pass_b, exp_pb);
      chk("srq_byp",    srq_a,  {ref_n, ref_z, ref_c, ref_v});
      chk("srq_nobyp",  srq_b,  {ref_n, ref_z, ref_c, ref_v});
      chk("cout_byp",   cout_a, ref_c);
      chk("cout_nobyp", cout_b, ref_c);
    end
    $display("txn t=%0t rst=%0b sr_in=%b upd=%0b cond=%h cv=%0b | pass=%0b/%0b hz=%0b sr_q=%b",
             $time, rst, sr_in, upd, cond_id, cond_valid, pass_a, pass_b, hz_b, srq_a);
    @(posedge clk);
    if (rst) begin
      {ref_n, ref_z, ref_c, ref_v} = 4'b0000;
      ref_known = 1'b1;
    end else if (upd) begin
      {ref_n, ref_z, ref_c, ref_v} = sr_in;
    end
    #1;
  endtask

  task automatic drive(input bit r, input logic [3:0] s, input bit ev, input bit se,
                       input bit fz, input logic [3:0] c, input bit cv);
    rst = r; sr_in = s; exe_valid = ev; s_exe = se; freeze = fz;
    cond_id = c; cond_valid = cv;
  endtask

  initial begin
    drive(1, 4'h0, 0, 0, 0, 4'h0, 1);
    @(posedge clk); #1;

    // 1: reset, then EQ fails and NE passes on zero flags
    cycle();
    cycle();
    chk("rst_srq", srq_a, 4'b0000);
    drive(0, 4'h0, 0, 0, 0, 4'h0, 1); #1;
    chk("rst_eq", pass_a, 1'b0);
    cycle();
    drive(0, 4'h0, 0, 0, 0, 4'h1, 1); #1;
    chk("rst_ne", pass_a, 1'b1);
    cycle();

    // 2: Z commit with bypassed EQ in the same cycle
    drive(0, 4'b0100, 1, 1, 0, 4'h0, 1); #1;
    chk("byp_eq", pass_a, 1'b1);
    cycle();
    chk("commit_srq", srq_a, 4'b0100);

    // 3: freeze blocks the commit and the bypass
    drive(0, 4'b1000, 1, 1, 1, 4'h4, 1); #1;
    chk("frz_mi", pass_a, 1'b0);
    cycle();
    chk("frz_srq", srq_a, 4'b0100);

    // 4: sweep all 16 committed values across all 16 conditions
    for (int v = 0; v < 16; v++) begin
      drive(0, 4'(v), 1, 1, 0, 4'hE, 0);
      cycle();
      for (int c = 0; c < 16; c++) begin
        drive(0, 4'(v ^ 4'hF), 1, 0, 0, 4'(c), 1);
        cycle();
      end
    end
    drive(0, 4'b1001, 1, 1, 0, 4'hA, 0); cycle();
    drive(0, 4'h0, 0, 0, 0, 4'hA, 1); #1; chk("ge_1001", pass_a, 1'b1); cycle();
    drive(0, 4'b1000, 1, 1, 0, 4'hB, 0); cycle();
    drive(0, 4'h0, 0, 0, 0, 4'hB, 1); #1; chk("lt_1000", pass_a, 1'b1); cycle();
    drive(0, 4'b0010, 1, 1, 0, 4'h8, 0); cycle();
    drive(0, 4'h0, 0, 0, 0, 4'h8, 1); #1; chk("hi_0010", pass_a, 1'b1); cycle();

    // 5: hazard raised without the bypass, except for unconditional codes
    drive(0, 4'b0100, 1, 1, 0, 4'h1, 1); #1;
    chk("hz_ne", hz_b, 1'b1);
    cycle();
    drive(0, 4'b0100, 1, 1, 0, 4'hE, 1); #1;
    chk("hz_al", hz_b, 1'b0);
    cycle();

    // 6: carry comes from committed flags only; reset beats commit
    drive(0, 4'b0010, 1, 1, 0, 4'hE, 1); cycle();
    drive(0, 4'b0000, 1, 1, 0, 4'hE, 1); #1;
    chk("adc_cout_now", cout_a, 1'b1);
    cycle();
    chk("adc_cout_next", cout_a, 1'b0);
    drive(0, 4'b1111, 1, 1, 0, 4'hE, 1); cycle();
    drive(1, 4'b1111, 1, 1, 0, 4'hE, 1); cycle();
    chk("rst_over_commit", srq_a, 4'b0000);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
